meter_ctrl: RTL

//  Sequencer for the parking-meter time counter. Owns the 14-bit seconds count (0..9999).

---
 rtl/meter_pkg.sv | 53 +++++
 rtl/meter_ctrl_if.sv | 28 ++
 rtl/meter_prescaler.sv | 45 ++++
 rtl/meter_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/meter_pkg.sv
// Shared types and constants for the parking-meter time sequencer.
package meter_pkg;

  localparam int COUNT_W    = 14;
  localparam int MAX_COUNT  = 9999;
  localparam int LOW_THRESH = 200;

  localparam int ADD_U    = 10;
  localparam int ADD_L    = 180;
  localparam int ADD_R    = 200;
  localparam int ADD_D    = 550;
  localparam int PRESET_A = 10;
  localparam int PRESET_B = 205;

  // Pending-register bit positions; a higher index means higher priority.
  localparam int P_TICK   = 0;
  localparam int P_ADD_U  = 1;
  localparam int P_ADD_L  = 2;
  localparam int P_ADD_R  = 3;
  localparam int P_ADD_D  = 4;
  localparam int P_PRE10  = 5;
  localparam int P_PRE205 = 6;
  localparam int NPEND    = 7;

  typedef enum logic [1:0] {
    MODE_EXPIRED = 2'b00,
    MODE_LOW     = 2'b01,
    MODE_NORMAL  = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    OP_TICK = 2'd0,
    OP_ADD  = 2'd1,
    OP_LOAD = 2'd2
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_UPD  = 1'b1
  } state_e;

  // Display mode as a pure function of the seconds count.
  function automatic mode_e mode_of(input logic [COUNT_W-1:0] cnt,
                                    input logic [COUNT_W-1:0] low_thresh);
    if (cnt == '0)
      return MODE_EXPIRED;
    else if (cnt < low_thresh)
      return MODE_LOW;
    else
      return MODE_NORMAL;
  endfunction

endpackage

// File: rtl/meter_ctrl_if.sv
// Button-pulse inputs and display-facing outputs of the meter sequencer.
interface meter_ctrl_if;
  import meter_pkg::*;

  logic               add_u;
  logic               add_l;
  logic               add_r;
  logic               add_d;
  logic               preset10;
  logic               preset205;
  logic [COUNT_W-1:0] count;
  logic [1:0]         mode;
  logic               blink_on;
  logic               sec_tick;

  // Debouncer / stimulus side.
  modport master (
    output add_u, add_l, add_r, add_d, preset10, preset205,
    input  count, mode, blink_on, sec_tick
  );

  // Sequencer side.
  modport slave (
    input  add_u, add_l, add_r, add_d, preset10, preset205,
    output count, mode, blink_on, sec_tick
  );

endinterface

// File: rtl/meter_prescaler.sv
// One-second prescaler: wraps every CLK_HZ cycles, flags the first half-second.
module meter_prescaler #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic restart_i,
  output logic sec_tick_o,
  output logic half_sec_o
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] HALF = PW'(CLK_HZ / 2);

  logic [PW-1:0] cnt_q, cnt_d;
  logic          sec_tick_q, sec_tick_d;

  // Next count: restart wins over the natural wrap so a restart never emits a tick.
  always_comb begin
    cnt_d      = cnt_q + 1'b1;
    sec_tick_d = 1'b0;
    if (restart_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d      = '0;
      sec_tick_d = 1'b1;
    end
  end

  // Counter and tick registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      sec_tick_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      sec_tick_q <= sec_tick_d;
    end
  end

  assign sec_tick_o = sec_tick_q;
  assign half_sec_o = (cnt_q < HALF);

endmodule

// File: rtl/meter_ctrl.sv
// Parking-meter sequencer: arbitrates button pulses and the 1 Hz tick onto the
// seconds count, and derives display mode and blink for the anode/segment FSM.
module meter_ctrl
  import meter_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int MAX_COUNT  = meter_pkg::MAX_COUNT,
  parameter int LOW_THRESH = meter_pkg::LOW_THRESH,
  parameter int ADD_U      = meter_pkg::ADD_U,
  parameter int ADD_L      = meter_pkg::ADD_L,
  parameter int ADD_R      = meter_pkg::ADD_R,
  parameter int ADD_D      = meter_pkg::ADD_D,
  parameter int PRESET_A   = meter_pkg::PRESET_A,
  parameter int PRESET_B   = meter_pkg::PRESET_B
) (
  input logic           clk,
  input logic           reset,
  meter_ctrl_if.slave   bus
);

  localparam logic [COUNT_W-1:0] MAX_C  = COUNT_W'(MAX_COUNT);
  localparam logic [COUNT_W-1:0] LOW_C  = COUNT_W'(LOW_THRESH);
  localparam logic [COUNT_W-1:0] ADD_UC = COUNT_W'(ADD_U);
  localparam logic [COUNT_W-1:0] ADD_LC = COUNT_W'(ADD_L);
  localparam logic [COUNT_W-1:0] ADD_RC = COUNT_W'(ADD_R);
  localparam logic [COUNT_W-1:0] ADD_DC = COUNT_W'(ADD_D);
  localparam logic [COUNT_W-1:0] PRE_AC = COUNT_W'(PRESET_A);
  localparam logic [COUNT_W-1:0] PRE_BC = COUNT_W'(PRESET_B);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [COUNT_W-1:0] operand_q, operand_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [NPEND-1:0]   pend_q, pend_d;
  logic [NPEND-1:0]   pulse_vec;
  logic [NPEND-1:0]   grant;
  logic               phase_q, phase_d;
  logic               restart;
  logic               sec_tick;
  logic               half_sec;
  logic [COUNT_W:0]   sum;
  mode_e              mode_c;
  logic               blink_c;

  meter_prescaler #(
    .CLK_HZ (CLK_HZ)
  ) u_prescaler (
    .clk        (clk),
    .reset      (reset),
    .restart_i  (restart),
    .sec_tick_o (sec_tick),
    .half_sec_o (half_sec)
  );

  assign pulse_vec = {bus.preset205, bus.preset10, bus.add_d, bus.add_r,
                      bus.add_l, bus.add_u, sec_tick};

  // Fixed-priority grant: a pending bit wins only if no higher bit is pending.
  for (genvar gi = 0; gi < NPEND; gi++) begin : g_grant
    assign grant[gi] = pend_q[gi] & ~(|(pend_q >> (gi + 1)));
  end

  // Saturating add is done one bit wider so overflow past MAX_COUNT is visible.
  assign sum = {1'b0, count_q} + {1'b0, operand_q};

  // FSM next state: grant and latch an operation in IDLE, commit it in UPD.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    operand_d = operand_q;
    count_d   = count_q;
    restart   = 1'b0;
    // A repeat pulse of an already-pending event merges into the same bit.
    pend_d    = pend_q | pulse_vec;

    unique case (state_q)
      ST_IDLE: begin
        if (|pend_q) begin
          state_d = ST_UPD;
          pend_d  = pend_d & ~grant;
          if (grant[P_PRE205]) begin
            op_d      = OP_LOAD;
            operand_d = PRE_BC;
          end else if (grant[P_PRE10]) begin
            op_d      = OP_LOAD;
            operand_d = PRE_AC;
          end else if (grant[P_ADD_D]) begin
            op_d      = OP_ADD;
            operand_d = ADD_DC;
          end else if (grant[P_ADD_R]) begin
            op_d      = OP_ADD;
            operand_d = ADD_RC;
          end else if (grant[P_ADD_L]) begin
            op_d      = OP_ADD;
            operand_d = ADD_LC;
          end else if (grant[P_ADD_U]) begin
            op_d      = OP_ADD;
            operand_d = ADD_UC;
          end else begin
            op_d      = OP_TICK;
            operand_d = '0;
          end
          // A preset supersedes any queued adds/ticks and starts a fresh second.
          if (grant[P_PRE205] || grant[P_PRE10]) begin
            pend_d[P_ADD_D:P_TICK] = '0;
            restart                = 1'b1;
          end
        end
      end
      ST_UPD: begin
        state_d = ST_IDLE;
        unique case (op_q)
          OP_LOAD: count_d = operand_q;
          OP_ADD:  count_d = (sum > {1'b0, MAX_C}) ? MAX_C : sum[COUNT_W-1:0];
          default: count_d = (count_q != '0) ? count_q - 1'b1 : '0;
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, pending and count registers; reset drops any in-flight update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_TICK;
      operand_q <= '0;
      count_q   <= '0;
      pend_q    <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      operand_q <= operand_d;
      count_q   <= count_d;
      pend_q    <= pend_d;
    end
  end

  // Display mode and blink selection from the registered count.
  always_comb begin
    mode_c  = mode_of(count_q, LOW_C);
    blink_c = 1'b1;
    unique case (mode_c)
      MODE_LOW:     blink_c = phase_q;
      MODE_EXPIRED: blink_c = half_sec;
      default:      blink_c = 1'b1;
    endcase
  end

  // Blink phase toggles each second while LOW and is held lit otherwise.
  always_comb begin
    phase_d = phase_q;
    if (mode_c != MODE_LOW)
      phase_d = 1'b1;
    else if (sec_tick)
      phase_d = ~phase_q;
  end

  // Blink phase register.
  always_ff @(posedge clk) begin
    if (reset)
      phase_q <= 1'b1;
    else
      phase_q <= phase_d;
  end

  assign bus.count    = count_q;
  assign bus.mode     = mode_c;
  assign bus.blink_on = blink_c;
  assign bus.sec_tick = sec_tick;

endmodule
